// File: rtl/qnet_arb_pkg.sv
// Shared types and constants for the QNET command arbiter.
package qnet_arb_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_ACK  = 2'd1,
    WAIT_NACK = 2'd2
  } TYPE_ARB_ST;

  localparam logic SRC_LOC   = 1'b0;
  localparam logic SRC_NET   = 1'b1;
  localparam int   ARB_CNT_W = 12;

  // With both slots full the source not granted last time wins, so neither starves.
  function automatic logic pick_src(input logic loc_full, input logic net_full,
                                    input logic last_src);
    return (loc_full && net_full) ? ~last_src : net_full;
  endfunction

endpackage

// File: rtl/qnet_arb_slot.sv
// One-entry holding register for a command source; ready is the registered empty flag.
module qnet_arb_slot
  import qnet_arb_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int DT_W = 32
) (
  input  logic            st_clk_i,
  input  logic            st_rst_i,
  input  logic            vld,
  output logic            rdy,
  input  logic [OP_W-1:0] op,
  input  logic [DT_W-1:0] dt,
  input  logic            clr,
  output logic            full,
  output logic [OP_W-1:0] hold_op,
  output logic [DT_W-1:0] hold_dt
);

  logic take;

  assign take = vld && !full;
  assign rdy  = !full;

  always_ff @(posedge st_clk_i) begin
    if (st_rst_i) begin
      full <= 1'b0;
    end else if (clr) begin
      full <= 1'b0;
    end else if (take) begin
      full <= 1'b1;
    end
  end

  always_ff @(posedge st_clk_i) begin
    if (take) begin
      hold_op <= op;
      hold_dt <= dt;
    end
  end

endmodule

// File: rtl/qnet_cmd_arb.sv
// Arbitrates local and network commands into the QNET command FSM over a 4-phase req/ack,
// with ack timeout detection and per-source grant counters for debug.
module qnet_cmd_arb
  import qnet_arb_pkg::*;
#(
  parameter int OP_W = 5,
  parameter int DT_W = 32,
  parameter int TOUT = 1023
) (
  input  logic            st_clk_i,
  input  logic            st_rst_i,
  input  logic            loc_vld_i,
  output logic            loc_rdy_o,
  input  logic [OP_W-1:0] loc_op_i,
  input  logic [DT_W-1:0] loc_dt_i,
  input  logic            net_vld_i,
  output logic            net_rdy_o,
  input  logic [OP_W-1:0] net_op_i,
  input  logic [DT_W-1:0] net_dt_i,
  output logic            cmd_req_o,
  input  logic            cmd_ack_i,
  output logic [OP_W-1:0] cmd_op_o,
  output logic [DT_W-1:0] cmd_dt_o,
  output logic            cmd_src_o,
  input  logic            err_clr_i,
  output logic            err_o,
  output logic            busy_o,
  output logic [31:0]     arb_dbg_o
);

  localparam logic [15:0] TOUT_LAST = 16'(TOUT - 1);

  TYPE_ARB_ST           state;
  logic [15:0]          tout_cnt;
  logic                 last_src;
  logic [ARB_CNT_W-1:0] loc_cnt;
  logic [ARB_CNT_W-1:0] net_cnt;

  logic            loc_full, net_full;
  logic [OP_W-1:0] loc_op, net_op;
  logic [DT_W-1:0] loc_dt, net_dt;
  logic            grant, gsrc;

  // A stale ack still high in IDLE blocks new grants until it drops.
  assign grant = (state == IDLE) && !cmd_ack_i && (loc_full || net_full);
  assign gsrc  = pick_src(loc_full, net_full, last_src);

  qnet_arb_slot #(.OP_W(OP_W), .DT_W(DT_W)) u_loc_slot (
    .st_clk_i (st_clk_i),
    .st_rst_i (st_rst_i),
    .vld      (loc_vld_i),
    .rdy      (loc_rdy_o),
    .op       (loc_op_i),
    .dt       (loc_dt_i),
    .clr      (grant && (gsrc == SRC_LOC)),
    .full     (loc_full),
    .hold_op  (loc_op),
    .hold_dt  (loc_dt)
  );

  qnet_arb_slot #(.OP_W(OP_W), .DT_W(DT_W)) u_net_slot (
    .st_clk_i (st_clk_i),
    .st_rst_i (st_rst_i),
    .vld      (net_vld_i),
    .rdy      (net_rdy_o),
    .op       (net_op_i),
    .dt       (net_dt_i),
    .clr      (grant && (gsrc == SRC_NET)),
    .full     (net_full),
    .hold_op  (net_op),
    .hold_dt  (net_dt)
  );

  always_ff @(posedge st_clk_i) begin
    if (st_rst_i) begin
      state     <= IDLE;
      tout_cnt  <= '0;
      last_src  <= SRC_NET;
      loc_cnt   <= '0;
      net_cnt   <= '0;
      cmd_req_o <= 1'b0;
      cmd_op_o  <= '0;
      cmd_dt_o  <= '0;
      cmd_src_o <= SRC_LOC;
      err_o     <= 1'b0;
    end else begin
      // A timeout below overrides a clear on the same edge.
      if (err_clr_i) err_o <= 1'b0;
      case (state)
        IDLE: begin
          if (grant) begin
            cmd_op_o  <= (gsrc == SRC_NET) ? net_op : loc_op;
            cmd_dt_o  <= (gsrc == SRC_NET) ? net_dt : loc_dt;
            cmd_src_o <= gsrc;
            cmd_req_o <= 1'b1;
            last_src  <= gsrc;
            tout_cnt  <= '0;
            if (gsrc == SRC_NET) net_cnt <= net_cnt + 1'b1;
            else                 loc_cnt <= loc_cnt + 1'b1;
            state     <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (cmd_ack_i) begin
            cmd_req_o <= 1'b0;
            state     <= WAIT_NACK;
          end else if (tout_cnt == TOUT_LAST) begin
            err_o     <= 1'b1;
            cmd_req_o <= 1'b0;
            state     <= WAIT_NACK;
          end else begin
            tout_cnt  <= tout_cnt + 1'b1;
          end
        end
        WAIT_NACK: begin
          if (!cmd_ack_i) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy_o    = (state != IDLE) || loc_full || net_full;
  assign arb_dbg_o = {state, last_src, err_o, 4'b0, net_cnt, loc_cnt};

endmodule

// File: tb/tb_qnet_cmd_arb.sv
// Directed bench for qnet_cmd_arb: stimulus pushes expected grants, a monitor checks them.
module tb_qnet_cmd_arb;

  typedef struct {
    string       name;
    logic [63:0] act;
    logic [63:0] exp;
  } chk_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        loc_vld, net_vld, loc_rdy, net_rdy;
  logic [4:0]  loc_op, net_op, cmd_op;
  logic [31:0] loc_dt, net_dt, cmd_dt, dbg;
  logic        cmd_req, cmd_ack, cmd_src, err_clr, err, busy;

  logic        ack_auto = 1'b0;
  logic        ack_force;
  int          rsp_mode;
  int          ack_dly;
  int          rsp_cnt = 0;

  logic [63:0] exp_q[$];
  chk_t        chk_q[$];
  int          n_pass = 0;
  int          n_total = 0;
  logic        req_q = 1'b0;
  logic [63:0] held = '0;

  always #5 clk = ~clk;
  assign cmd_ack = ack_auto | ack_force;

  qnet_cmd_arb #(.OP_W(5), .DT_W(32), .TOUT(16)) dut (
    .st_clk_i  (clk),
    .st_rst_i  (rst),
    .loc_vld_i (loc_vld),
    .loc_rdy_o (loc_rdy),
    .loc_op_i  (loc_op),
    .loc_dt_i  (loc_dt),
    .net_vld_i (net_vld),
    .net_rdy_o (net_rdy),
    .net_op_i  (net_op),
    .net_dt_i  (net_dt),
    .cmd_req_o (cmd_req),
    .cmd_ack_i (cmd_ack),
    .cmd_op_o  (cmd_op),
    .cmd_dt_o  (cmd_dt),
    .cmd_src_o (cmd_src),
    .err_clr_i (err_clr),
    .err_o     (err),
    .busy_o    (busy),
    .arb_dbg_o (dbg)
  );

  // Command FSM model: mode 0 acks ack_dly cycles after req, 1 never acks, 2 manual.
  always @(negedge clk) begin
    if (rsp_mode == 0) begin
      if (cmd_req && !ack_auto) begin
        rsp_cnt = rsp_cnt + 1;
        if (rsp_cnt >= ack_dly) begin
          ack_auto = 1'b1;
          rsp_cnt  = 0;
        end
      end else if (!cmd_req) begin
        ack_auto = 1'b0;
        rsp_cnt  = 0;
      end
    end else begin
      ack_auto = 1'b0;
      rsp_cnt  = 0;
    end
  end

  task automatic eval(input string nm, input logic [63:0] a, input logic [63:0] e);
    n_total = n_total + 1;
    if (a === e) n_pass = n_pass + 1;
    else $display("FAIL %s: got %h, required %h", nm, a, e);
  endtask

  // Monitor: grants against the scoreboard, held command stability, queued direct checks.
  always @(negedge clk) begin
    logic [63:0] act;
    logic [63:0] e;
    chk_t        c;
    act = {26'd0, cmd_src, cmd_op, cmd_dt};
    if (cmd_req && !req_q) begin
      if (exp_q.size() == 0) begin
        eval("grant_unexpected", act, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        eval("grant", act, e);
      end
      held = act;
    end else if (cmd_req && req_q) begin
      eval("hold_stable", act, held);
    end
    req_q = cmd_req;
    while (chk_q.size() != 0) begin
      c = chk_q.pop_front();
      eval(c.name, c.act, c.exp);
    end
  end

  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    chk_q.push_back('{nm, a, e});
  endtask

  task automatic push_exp(input logic src, input logic [4:0] op, input logic [31:0] dt);
    exp_q.push_back({26'd0, src, op, dt});
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_idle(input string nm);
    int n = 0;
    while ((busy || cmd_req || cmd_ack) && n < 200) begin
      tick(1);
      n++;
    end
    chk(nm, 64'(busy), 64'd0);
  endtask

  task automatic wait_req(input string nm);
    int n = 0;
    while (!cmd_req && n < 20) begin
      tick(1);
      n++;
    end
    chk(nm, 64'(cmd_req), 64'd1);
  endtask

  task automatic send(input logic src, input logic [4:0] op, input logic [31:0] dt);
    if (src) begin
      net_vld = 1'b1; net_op = op; net_dt = dt;
    end else begin
      loc_vld = 1'b1; loc_op = op; loc_dt = dt;
    end
    push_exp(src, op, dt);
    tick(1);
    loc_vld = 1'b0;
    net_vld = 1'b0;
  endtask

  // Counts negedges with req high; optionally raises err_clr for the timeout edge.
  task automatic timeout_run(input bit clr_at_edge, output int n);
    n = 0;
    while (cmd_req && n < 100) begin
      n++;
      if (clr_at_edge && n == 16) err_clr = 1'b1;
      tick(1);
    end
    err_clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int k;
    int g;
    rst = 1'b1; loc_vld = 1'b0; net_vld = 1'b0; loc_op = '0; net_op = '0;
    loc_dt = '0; net_dt = '0; err_clr = 1'b0; ack_force = 1'b0;
    rsp_mode = 0; ack_dly = 2;
    tick(2);
    chk("rst_loc_rdy", 64'(loc_rdy), 64'd1);
    chk("rst_net_rdy", 64'(net_rdy), 64'd1);
    chk("rst_req", 64'(cmd_req), 64'd0);
    chk("rst_op_dt", {27'd0, cmd_op, cmd_dt}, 64'd0);
    chk("rst_src_err_busy", {61'd0, cmd_src, err, busy}, 64'd0);
    chk("rst_dbg", 64'(dbg), 64'h2000_0000);
    rst = 1'b0;
    tick(1);

    // 1: single local command, exact latency
    loc_vld = 1'b1; loc_op = 5'd3; loc_dt = 32'hA5A5_0001;
    push_exp(1'b0, 5'd3, 32'hA5A5_0001);
    tick(1);
    loc_vld = 1'b0;
    chk("t1_full_rdy", 64'(loc_rdy), 64'd0);
    chk("t1_req_n1", 64'(cmd_req), 64'd0);
    tick(1);
    chk("t1_req_n2", 64'(cmd_req), 64'd1);
    chk("t1_rdy_n2", 64'(loc_rdy), 64'd1);
    wait_idle("t1_idle");
    chk("t1_loc_cnt", 64'(dbg[11:0]), 64'd1);
    chk("t1_dbg", 64'(dbg), 64'h0000_0001);

    // 2: both sources together, alternation from reset
    rst = 1'b1; tick(1); rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      loc_vld = 1'b1; loc_op = 5'(i + 1);  loc_dt = 32'h1000_0000 + 32'(i);
      net_vld = 1'b1; net_op = 5'(i + 16); net_dt = 32'h2000_0000 + 32'(i);
      push_exp(1'b0, 5'(i + 1), 32'h1000_0000 + 32'(i));
      push_exp(1'b1, 5'(i + 16), 32'h2000_0000 + 32'(i));
      tick(1);
      loc_vld = 1'b0; net_vld = 1'b0;
      wait_idle("t2_idle");
    end
    chk("t2_loc_cnt", 64'(dbg[11:0]), 64'd4);
    chk("t2_net_cnt", 64'(dbg[23:12]), 64'd4);

    // 3: no ack -> timeout after 16 cycles, clear, then clear colliding with set
    rsp_mode = 1;
    send(1'b0, 5'd7, 32'hDEAD_0007);
    wait_req("t3_req");
    timeout_run(1'b0, n);
    chk("t3_req_cycles", 64'(n), 64'd16);
    chk("t3_err", 64'(err), 64'd1);
    chk("t3_dbg_err", 64'(dbg[28]), 64'd1);
    wait_idle("t3_idle");
    err_clr = 1'b1; tick(1); err_clr = 1'b0;
    chk("t3_err_clr", 64'(err), 64'd0);
    send(1'b1, 5'd9, 32'hDEAD_0009);
    wait_req("t3b_req");
    timeout_run(1'b1, n);
    chk("t3b_req_cycles", 64'(n), 64'd16);
    chk("t3b_set_wins", 64'(err), 64'd1);
    wait_idle("t3b_idle");
    err_clr = 1'b1; tick(1); err_clr = 1'b0;

    // 4: stale ack high in IDLE blocks grant until it drops
    rsp_mode = 2;
    ack_force = 1'b1;
    tick(1);
    send(1'b1, 5'd12, 32'h4444_000C);
    g = 0;
    for (int i = 0; i < 5; i++) begin
      if (cmd_req) g++;
      tick(1);
    end
    chk("t4_no_grant", 64'(g), 64'd0);
    ack_force = 1'b0;
    tick(1);
    chk("t4_grant_1cyc", 64'(cmd_req), 64'd1);
    ack_force = 1'b1;
    tick(1);
    chk("t4_req_drop", 64'(cmd_req), 64'd0);
    ack_force = 1'b0;
    wait_idle("t4_idle");
    chk("t4_hold_op", 64'(cmd_op), 64'd12);

    // 5: reset during WAIT_ACK with both slots full
    rsp_mode = 1;
    send(1'b0, 5'd21, 32'h5555_0015);
    wait_req("t5_req");
    loc_vld = 1'b1; loc_op = 5'd22; loc_dt = 32'h5555_0016;
    net_vld = 1'b1; net_op = 5'd23; net_dt = 32'h5555_0017;
    tick(1);
    loc_vld = 1'b0; net_vld = 1'b0;
    chk("t5_both_full", {62'd0, loc_rdy, net_rdy}, 64'd0);
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    chk("t5_req", 64'(cmd_req), 64'd0);
    chk("t5_rdy", {62'd0, loc_rdy, net_rdy}, 64'd3);
    chk("t5_dbg", 64'(dbg), 64'h2000_0000);
    chk("t5_busy", 64'(busy), 64'd0);

    // 6: network valid every cycle, ack after one cycle
    rsp_mode = 0; ack_dly = 1;
    k = 0; g = 0;
    while (k < 8 && g < 300) begin
      net_vld = 1'b1; net_op = 5'(k + 8); net_dt = 32'hC0DE_0000 + 32'(k);
      if (net_rdy) begin
        push_exp(1'b1, 5'(k + 8), 32'hC0DE_0000 + 32'(k));
        tick(1);
        k++;
      end else begin
        tick(1);
      end
      g++;
    end
    net_vld = 1'b0;
    wait_idle("t6_idle");
    chk("t6_accepted", 64'(k), 64'd8);
    chk("t6_net_cnt", 64'(dbg[23:12]), 64'd8);
    chk("t6_sb_empty", 64'(exp_q.size()), 64'd0);

    tick(3);
    n = 0;
    while (chk_q.size() != 0 && n < 10) begin
      tick(1);
      n++;
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
